// File: rtl/efc_row_xmit_if.sv
// Fuse-array read port bundle: row request/address out, ack/data back.
interface efc_row_xmit_if #(
    parameter int AW    = 2,
    parameter int WIDTH = 32
) ();
    logic             rd_req;
    logic [AW-1:0]    rd_addr;
    logic             rd_ack;
    logic [WIDTH-1:0] rd_data;

    modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
    modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface

// File: rtl/efc_row_xmit.sv
// Reads ROWS fuse rows and serializes each one MSB-first onto the latch chain.
module efc_row_xmit #(
    parameter int ROWS  = 4,
    parameter int WIDTH = 32,
    parameter int AW    = 2
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           start,
    input  logic           abort,
    efc_row_xmit_if.master rd_bus,
    output logic           xfer_en,
    output logic           xfer_data,
    output logic           busy,
    output logic           done
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           r_state, w_nxt_state;
    logic [AW-1:0]    r_row, w_nxt_row;
    logic [BW-1:0]    r_bit, w_nxt_bit;
    logic [WIDTH-1:0] r_sh, w_nxt_sh;
    logic             w_nxt_xd;
    logic             r_rd_req, r_xfer_en, r_xfer_data, r_busy, r_done;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_row   = r_row;
        w_nxt_bit   = r_bit;
        w_nxt_sh    = r_sh;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nxt_state = ST_REQ;
                    w_nxt_row   = '0;
                end
            end
            ST_REQ: begin
                if (rd_bus.rd_ack) begin
                    w_nxt_state = ST_SHIFT;
                    w_nxt_sh    = rd_bus.rd_data;
                    w_nxt_bit   = '0;
                end
            end
            ST_SHIFT: begin
                w_nxt_sh  = r_sh << 1;
                w_nxt_bit = r_bit + 1'b1;
                if (r_bit == LAST_BIT) begin
                    w_nxt_bit = '0;
                    if (r_row == LAST_ROW) begin
                        w_nxt_state = ST_DONE;
                    end else begin
                        w_nxt_row   = r_row + 1'b1;
                        w_nxt_state = ST_REQ;
                    end
                end
            end
            ST_DONE: w_nxt_state = ST_IDLE;
            default: w_nxt_state = ST_IDLE;
        endcase
        if (abort) begin
            w_nxt_state = ST_IDLE;
            w_nxt_row   = '0;
            w_nxt_bit   = '0;
            w_nxt_sh    = '0;
        end
        // Outputs are registered from the next state so they line up with it.
        w_nxt_xd = (w_nxt_state == ST_SHIFT) & w_nxt_sh[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state     <= ST_IDLE;
            r_row       <= '0;
            r_bit       <= '0;
            r_sh        <= '0;
            r_rd_req    <= 1'b0;
            r_xfer_en   <= 1'b0;
            r_xfer_data <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_row       <= w_nxt_row;
            r_bit       <= w_nxt_bit;
            r_sh        <= w_nxt_sh;
            r_rd_req    <= (w_nxt_state == ST_REQ);
            r_xfer_en   <= (w_nxt_state == ST_SHIFT);
            r_xfer_data <= w_nxt_xd;
            r_busy      <= (w_nxt_state != ST_IDLE);
            r_done      <= (w_nxt_state == ST_DONE);
        end
    end

    assign rd_bus.rd_req  = r_rd_req;
    assign rd_bus.rd_addr = r_row;
    assign xfer_en        = r_xfer_en;
    assign xfer_data      = r_xfer_data;
    assign busy           = r_busy;
    assign done           = r_done;
endmodule

// File: tb/tb_efc_row_xmit.sv
// Directed bench for efc_row_xmit: default 4x32 instance plus a 1x8 instance.
module tb_efc_row_xmit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic a_rst_l, a_start, a_abort, a_xfer_en, a_xfer_data, a_busy, a_done;
    logic b_rst_l, b_start, b_abort, b_xfer_en, b_xfer_data, b_busy, b_done;

    efc_row_xmit_if #(.AW(2), .WIDTH(32)) a_if ();
    efc_row_xmit_if #(.AW(1), .WIDTH(8))  b_if ();

    efc_row_xmit #(.ROWS(4), .WIDTH(32), .AW(2)) u_dut_a (
        .clk       (clk),
        .rst_l     (a_rst_l),
        .start     (a_start),
        .abort     (a_abort),
        .rd_bus    (a_if),
        .xfer_en   (a_xfer_en),
        .xfer_data (a_xfer_data),
        .busy      (a_busy),
        .done      (a_done)
    );

    efc_row_xmit #(.ROWS(1), .WIDTH(8), .AW(1)) u_dut_b (
        .clk       (clk),
        .rst_l     (b_rst_l),
        .start     (b_start),
        .abort     (b_abort),
        .rd_bus    (b_if),
        .xfer_en   (b_xfer_en),
        .xfer_data (b_xfer_data),
        .busy      (b_busy),
        .done      (b_done)
    );

    logic [31:0] rows [4] = '{32'hA5A5_0001, 32'h0000_0002, 32'hFFFF_FFFF, 32'h8000_0000};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one sequence on the 4x32 instance; ack comes on the 2nd REQ cycle
    // (6th on stall_row). kill_row/kill_bit inject abort or a 1-cycle reset.
    task automatic xmit_seq(input int stall_row, input bit spur_ack, input bit poke_start,
                            input int kill_row, input int kill_bit, input bit kill_rst,
                            input int exp_len);
        int rows_done = 0;
        int nbits     = 0;
        int req_wait  = 0;
        int ncyc      = 0;
        int busy_cyc  = 0;
        int dones     = 0;
        int xd_bad    = 0;
        int en_in_req = 0;
        bit ack_prev  = 0;
        bit finished  = 0;
        bit kill      = 0;
        logic [31:0] word = '0;

        @(negedge clk);
        a_start = 1'b1;
        while (!finished && ncyc < 400) begin
            @(negedge clk);
            ncyc++;
            a_start = 1'b0;
            if (ack_prev) chk("req_drop", a_if.rd_req, 0);
            ack_prev = 0;
            if (a_busy) busy_cyc++;
            if (a_done) begin
                dones++;
                finished = 1;
            end
            if (!a_xfer_en && a_xfer_data) xd_bad++;
            a_if.rd_ack  = 1'b0;
            a_if.rd_data = 32'hDEAD_BEEF;
            if (a_if.rd_req) begin
                chk("rd_addr", a_if.rd_addr, rows_done);
                if (a_xfer_en) en_in_req++;
                if (kill_rst && rows_done == kill_row) begin
                    kill = 1;
                end else if (req_wait == ((rows_done == stall_row) ? 5 : 1)) begin
                    a_if.rd_ack  = 1'b1;
                    a_if.rd_data = rows[rows_done];
                    req_wait     = 0;
                    ack_prev     = 1;
                end else begin
                    req_wait++;
                end
            end else if (spur_ack) begin
                a_if.rd_ack = 1'b1;
            end
            if (a_xfer_en) begin
                word = {word[30:0], a_xfer_data};
                nbits++;
                if (!kill_rst && rows_done == kill_row && nbits == kill_bit + 1) kill = 1;
                if (nbits == 32) begin
                    chk("row_data", word, rows[rows_done]);
                    rows_done++;
                    nbits = 0;
                end
                if (poke_start && rows_done == 1 && nbits == 5) a_start = 1'b1;
            end
            if (kill) begin
                if (kill_rst) a_rst_l = 1'b0;
                else a_abort = 1'b1;
                a_start     = 1'b1;
                a_if.rd_ack = 1'b1;
                @(negedge clk);
                a_rst_l     = 1'b1;
                a_abort     = 1'b0;
                a_start     = 1'b0;
                a_if.rd_ack = 1'b0;
                chk("kill_busy", a_busy, 0);
                chk("kill_rd_req", a_if.rd_req, 0);
                chk("kill_xfer_en", a_xfer_en, 0);
                chk("kill_xfer_data", a_xfer_data, 0);
                chk("kill_done", a_done, 0);
                if (kill_rst) chk("kill_rd_addr", a_if.rd_addr, 0);
                repeat (6) begin
                    @(negedge clk);
                    if (a_done) dones++;
                end
                chk("kill_no_done", dones, 0);
                chk("kill_idle", a_busy, 0);
                return;
            end
        end
        chk("seq_complete", finished, 1);
        chk("seq_len", busy_cyc, exp_len);
        chk("seq_rows", rows_done, 4);
        chk("xfer_en_in_req", en_in_req, 0);
        chk("xfer_data_idle", xd_bad, 0);
        repeat (3) begin
            @(negedge clk);
            if (a_done) dones++;
        end
        chk("one_done", dones, 1);
        chk("idle_after", a_busy, 0);
    endtask

    initial begin
        int bcyc;
        int bnb;
        int bdone_at;
        bit bdone;
        logic [7:0] bw;

        a_rst_l = 1'b0; a_start = 1'b0; a_abort = 1'b0;
        b_rst_l = 1'b0; b_start = 1'b0; b_abort = 1'b0;
        a_if.rd_ack = 1'b0; a_if.rd_data = '0;
        b_if.rd_ack = 1'b0; b_if.rd_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_rd_req", a_if.rd_req, 0);
        chk("rst_rd_addr", a_if.rd_addr, 0);
        chk("rst_xfer_en", a_xfer_en, 0);
        chk("rst_xfer_data", a_xfer_data, 0);
        chk("rst_done", a_done, 0);
        chk("rst_b_busy", b_busy, 0);
        a_rst_l = 1'b1;
        b_rst_l = 1'b1;

        xmit_seq(-1, 1'b0, 1'b0, -1, -1, 1'b0, 137);  // nominal
        xmit_seq(2, 1'b1, 1'b0, -1, -1, 1'b0, 141);   // stall row 2, stray acks
        xmit_seq(-1, 1'b0, 1'b0, 1, 10, 1'b0, 0);     // abort at bit 10 of row 1
        xmit_seq(-1, 1'b0, 1'b0, -1, -1, 1'b0, 137);  // restart from row 0
        xmit_seq(-1, 1'b0, 1'b1, -1, -1, 1'b0, 137);  // start while busy
        xmit_seq(-1, 1'b0, 1'b0, 2, 0, 1'b1, 0);      // reset during REQ of row 2

        @(negedge clk);
        a_rst_l = 1'b0;
        @(negedge clk);
        a_rst_l = 1'b1;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("rel_start_busy", a_busy, 1);
        chk("rel_start_req", a_if.rd_req, 1);
        chk("rel_start_addr", a_if.rd_addr, 0);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        chk("rel_abort_busy", a_busy, 0);

        bcyc = 0; bnb = 0; bdone_at = 0; bdone = 0; bw = '0;
        @(negedge clk);
        b_start = 1'b1;
        for (int i = 0; i < 50 && !bdone; i++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_busy) bcyc++;
            if (b_if.rd_req) chk("b_rd_addr", b_if.rd_addr, 0);
            if (b_xfer_en) begin
                bw = {bw[6:0], b_xfer_data};
                bnb++;
            end
            if (b_done) begin
                bdone    = 1;
                bdone_at = bcyc;
            end
            b_if.rd_ack  = b_if.rd_req;
            b_if.rd_data = b_if.rd_req ? 8'h81 : 8'h00;
        end
        chk("b_done_seen", bdone, 1);
        chk("b_done_cycle", bdone_at, 10);
        chk("b_bits", bw, 8'h81);
        chk("b_nbits", bnb, 8);
        @(negedge clk);
        chk("b_idle", b_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
